// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared RV32I pipeline definitions: instruction-class bit positions,
// the data-memory watchdog state type and the x0 register index.
package rv32_pkg;

    localparam int unsigned CLASS_W    = 9;
    localparam int unsigned CLS_R      = 8;
    localparam int unsigned CLS_I      = 7;
    localparam int unsigned CLS_LOAD   = 6;
    localparam int unsigned CLS_STORE  = 5;
    localparam int unsigned CLS_BRANCH = 4;
    localparam int unsigned CLS_JAL    = 3;
    localparam int unsigned CLS_JALR   = 2;
    localparam int unsigned CLS_LUI    = 1;
    localparam int unsigned CLS_AUIPC  = 0;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } wd_state_e;

    localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-facing signal bundle of the hazard controller: ID-stage decode,
// EX redirect, data-memory handshake and the per-stage control outputs.
interface pipe_hazard_ctrl_if;
    import rv32_pkg::*;

    logic               id_valid;
    logic [CLASS_W-1:0] id_class;
    logic [4:0]         id_rs1;
    logic [4:0]         id_rs2;
    logic [4:0]         id_rd;
    logic               ex_redirect;
    logic               dmem_ready;

    logic               dmem_req;
    logic               stall_if;
    logic               stall_id;
    logic               stall_ex;
    logic               stall_mem;
    logic               flush_id;
    logic               flush_ex;
    logic               bubble_ex;
    logic               mem_err;

    modport master (
        output id_valid, id_class, id_rs1, id_rs2, id_rd, ex_redirect, dmem_ready,
        input  dmem_req, stall_if, stall_id, stall_ex, stall_mem,
               flush_id, flush_ex, bubble_ex, mem_err
    );

    modport slave (
        input  id_valid, id_class, id_rs1, id_rs2, id_rd, ex_redirect, dmem_ready,
        output dmem_req, stall_if, stall_id, stall_ex, stall_mem,
               flush_id, flush_ex, bubble_ex, mem_err
    );

endinterface

// File: rtl/pipe_hazard_ctrl_watchdog.sv
// Data-memory wait tracker: RUN/MEM_WAIT FSM with a wait-cycle counter that
// produces the pipeline freeze and a one-cycle timeout pulse.
module hazard_mem_watchdog
    import rv32_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_dmem_req,
    input  logic i_dmem_ready,
    output logic o_freeze,
    output logic o_mem_err
);

    localparam int unsigned        CNT_BITS = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_BITS-1:0] LAST    = CNT_BITS'(MEM_TIMEOUT - 1);

    wd_state_e           r_state;
    logic [CNT_BITS-1:0] r_cnt;
    logic                w_freeze;
    logic                w_timeout;

    // r_cnt holds the number of wait cycles already elapsed, so the first
    // frozen cycle (still in RUN) sees 0 and the timeout lands on wait cycle MEM_TIMEOUT.
    assign w_freeze  = i_dmem_req & ~i_dmem_ready;
    assign w_timeout = w_freeze & (r_cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RUN;
            r_cnt   <= '0;
        end else begin
            unique case (r_state)
                RUN: begin
                    if (w_freeze && !w_timeout) begin
                        r_state <= MEM_WAIT;
                        r_cnt   <= r_cnt + 1'b1;
                    end else begin
                        r_cnt   <= '0;
                    end
                end
                MEM_WAIT: begin
                    if (!w_freeze || w_timeout) begin
                        r_state <= RUN;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt   <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= RUN;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign o_freeze  = w_freeze;
    assign o_mem_err = w_timeout;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage RV32I pipeline.
// Optional performance counters enabled by defining PIPE_HAZARD_PERF_EN.
module pipe_hazard_ctrl
    import rv32_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    pipe_hazard_ctrl_if.slave bus
`ifdef PIPE_HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0] perf_stall_cnt,
    output logic [CNT_W-1:0] perf_flush_cnt
`endif
);

    logic       r_ex_v;
    logic       r_ex_ld;
    logic       r_ex_st;
    logic [4:0] r_ex_rd;
    logic       r_mem_v;
    logic       r_mem_memop;

    logic w_is_load, w_is_store;
    logic w_uses_rs1, w_uses_rs2;
    logic w_lu, w_dmem_req, w_freeze, w_mem_err;
    logic w_flush, w_bubble, w_ex_v_next;
    logic w_unused_cls;

    logic w_stall_if, w_stall_id, w_stall_ex, w_stall_mem;
    logic w_flush_id, w_flush_ex, w_bubble_ex, w_dmem_req_o, w_mem_err_o;

    assign w_is_load  = bus.id_class[CLS_LOAD];
    assign w_is_store = bus.id_class[CLS_STORE];
    assign w_uses_rs1 = ~(bus.id_class[CLS_LUI] | bus.id_class[CLS_AUIPC] | bus.id_class[CLS_JAL]);
    assign w_uses_rs2 = bus.id_class[CLS_R] | bus.id_class[CLS_STORE] | bus.id_class[CLS_BRANCH];
    assign w_unused_cls = bus.id_class[CLS_I] ^ bus.id_class[CLS_JALR];

    assign w_lu = bus.id_valid & r_ex_v & r_ex_ld & (r_ex_rd != REG_X0) &
                  ((w_uses_rs1 & (bus.id_rs1 == r_ex_rd)) |
                   (w_uses_rs2 & (bus.id_rs2 == r_ex_rd)));

    assign w_dmem_req = r_mem_v & r_mem_memop;

    hazard_mem_watchdog #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_watchdog (
        .clk          (clk),
        .rst          (rst),
        .i_dmem_req   (w_dmem_req),
        .i_dmem_ready (bus.dmem_ready),
        .o_freeze     (w_freeze),
        .o_mem_err    (w_mem_err)
    );

    // Redirect outranks the load-use stall; freeze outranks both.
    assign w_flush     = ~w_freeze & bus.ex_redirect;
    assign w_bubble    = ~w_freeze & ~bus.ex_redirect & w_lu;
    assign w_ex_v_next = bus.id_valid & ~(w_bubble | w_flush);

    always_comb begin
        w_dmem_req_o = 1'b0;
        w_stall_if   = 1'b0;
        w_stall_id   = 1'b0;
        w_stall_ex   = 1'b0;
        w_stall_mem  = 1'b0;
        w_flush_id   = 1'b0;
        w_flush_ex   = 1'b0;
        w_bubble_ex  = 1'b0;
        w_mem_err_o  = 1'b0;
        if (!rst) begin
            w_dmem_req_o = w_dmem_req;
            w_mem_err_o  = w_mem_err;
            if (w_freeze) begin
                w_stall_if  = 1'b1;
                w_stall_id  = 1'b1;
                w_stall_ex  = 1'b1;
                w_stall_mem = 1'b1;
            end else if (w_flush) begin
                w_flush_id = 1'b1;
                w_flush_ex = 1'b1;
            end else if (w_bubble) begin
                w_stall_if  = 1'b1;
                w_stall_id  = 1'b1;
                w_bubble_ex = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex_v      <= 1'b0;
            r_ex_ld     <= 1'b0;
            r_ex_st     <= 1'b0;
            r_ex_rd     <= REG_X0;
            r_mem_v     <= 1'b0;
            r_mem_memop <= 1'b0;
        end else if (w_freeze) begin
            // A timed-out access is abandoned so the freeze ends next cycle.
            if (w_mem_err) begin
                r_mem_v <= 1'b0;
            end
        end else begin
            r_ex_v      <= w_ex_v_next;
            r_ex_ld     <= w_is_load & w_ex_v_next;
            r_ex_st     <= w_is_store & w_ex_v_next;
            r_ex_rd     <= bus.id_rd;
            r_mem_v     <= r_ex_v & ~w_flush;
            r_mem_memop <= r_ex_ld | r_ex_st;
        end
    end

    assign bus.dmem_req  = w_dmem_req_o;
    assign bus.stall_if  = w_stall_if;
    assign bus.stall_id  = w_stall_id;
    assign bus.stall_ex  = w_stall_ex;
    assign bus.stall_mem = w_stall_mem;
    assign bus.flush_id  = w_flush_id;
    assign bus.flush_ex  = w_flush_ex;
    assign bus.bubble_ex = w_bubble_ex;
    assign bus.mem_err   = w_mem_err_o;

`ifdef PIPE_HAZARD_PERF_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_if && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_flush_id && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    assign perf_stall_cnt = r_stall_cnt;
    assign perf_flush_cnt = r_flush_cnt;
`endif

endmodule
